// File: rtl/snake_cmd_pkg.sv
// Shared definitions for the snake command hub: direction encoding, key
// codes, FSM state encoding and the byte decoder used by snake_cmd_hub.
// Optional feature macro (used in snake_cmd_hub): SNAKE_CMD_CASE_FOLD_EN.
package snake_cmd_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_RIGHT = 2'd0;
    localparam dir_t DIR_UP    = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_DOWN  = 2'd3;

    // Key codes, each player group in RIGHT/UP/LEFT/DOWN order.
    localparam logic [7:0] KEY_P0_RIGHT = 8'h64; // 'd'
    localparam logic [7:0] KEY_P0_UP    = 8'h77; // 'w'
    localparam logic [7:0] KEY_P0_LEFT  = 8'h61; // 'a'
    localparam logic [7:0] KEY_P0_DOWN  = 8'h73; // 's'
    localparam logic [7:0] KEY_P1_RIGHT = 8'h6C; // 'l'
    localparam logic [7:0] KEY_P1_UP    = 8'h69; // 'i'
    localparam logic [7:0] KEY_P1_LEFT  = 8'h6A; // 'j'
    localparam logic [7:0] KEY_P1_DOWN  = 8'h6B; // 'k'
    localparam logic [7:0] KEY_P2_RIGHT = 8'h36; // '6'
    localparam logic [7:0] KEY_P2_UP    = 8'h38; // '8'
    localparam logic [7:0] KEY_P2_LEFT  = 8'h34; // '4'
    localparam logic [7:0] KEY_P2_DOWN  = 8'h32; // '2'
    localparam logic [7:0] KEY_P3_RIGHT = 8'h68; // 'h'
    localparam logic [7:0] KEY_P3_UP    = 8'h74; // 't'
    localparam logic [7:0] KEY_P3_LEFT  = 8'h66; // 'f'
    localparam logic [7:0] KEY_P3_DOWN  = 8'h67; // 'g'
    localparam logic [7:0] KEY_PAUSE    = 8'h70; // 'p'
    localparam logic [7:0] KEY_RESTART  = 8'h72; // 'r'

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    typedef struct packed {
        logic       is_dir;
        logic [1:0] player;
        dir_t       dir;
        logic       is_pause;
        logic       is_restart;
    } key_t;

    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

    // Classify one received byte; unknown bytes decode to all-zero.
    function automatic key_t decode_key(input logic [7:0] b);
        key_t k;
        k = '0;
        case (b)
            KEY_P0_RIGHT: begin k.is_dir = 1'b1; k.player = 2'd0; k.dir = DIR_RIGHT; end
            KEY_P0_UP:    begin k.is_dir = 1'b1; k.player = 2'd0; k.dir = DIR_UP;    end
            KEY_P0_LEFT:  begin k.is_dir = 1'b1; k.player = 2'd0; k.dir = DIR_LEFT;  end
            KEY_P0_DOWN:  begin k.is_dir = 1'b1; k.player = 2'd0; k.dir = DIR_DOWN;  end
            KEY_P1_RIGHT: begin k.is_dir = 1'b1; k.player = 2'd1; k.dir = DIR_RIGHT; end
            KEY_P1_UP:    begin k.is_dir = 1'b1; k.player = 2'd1; k.dir = DIR_UP;    end
            KEY_P1_LEFT:  begin k.is_dir = 1'b1; k.player = 2'd1; k.dir = DIR_LEFT;  end
            KEY_P1_DOWN:  begin k.is_dir = 1'b1; k.player = 2'd1; k.dir = DIR_DOWN;  end
            KEY_P2_RIGHT: begin k.is_dir = 1'b1; k.player = 2'd2; k.dir = DIR_RIGHT; end
            KEY_P2_UP:    begin k.is_dir = 1'b1; k.player = 2'd2; k.dir = DIR_UP;    end
            KEY_P2_LEFT:  begin k.is_dir = 1'b1; k.player = 2'd2; k.dir = DIR_LEFT;  end
            KEY_P2_DOWN:  begin k.is_dir = 1'b1; k.player = 2'd2; k.dir = DIR_DOWN;  end
            KEY_P3_RIGHT: begin k.is_dir = 1'b1; k.player = 2'd3; k.dir = DIR_RIGHT; end
            KEY_P3_UP:    begin k.is_dir = 1'b1; k.player = 2'd3; k.dir = DIR_UP;    end
            KEY_P3_LEFT:  begin k.is_dir = 1'b1; k.player = 2'd3; k.dir = DIR_LEFT;  end
            KEY_P3_DOWN:  begin k.is_dir = 1'b1; k.player = 2'd3; k.dir = DIR_DOWN;  end
            KEY_PAUSE:    k.is_pause   = 1'b1;
            KEY_RESTART:  k.is_restart = 1'b1;
            default:      k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Per-player direction FIFO. Exposes the most recently written entry so the
// turn filter can compare against it, plus a synchronous flush for restart.
module snake_cmd_fifo
    import snake_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  dir_t                       din_i,
    output dir_t                       dout_o,
    output dir_t                       last_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    dir_t          mem_q [DEPTH];
    dir_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = din_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential blocks use non-blocking (<=) so all flops update together at the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; entries are only read when count_q says they are valid.
        mem_q <= mem_d;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign last_o  = mem_q[wr_ptr_q - PW'(1)];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/snake_cmd_hub.sv
// Multi-player command front-end: decodes UART bytes into per-player turns,
// filters illegal turns, buffers them and releases one per player per tick.
// Optional macro SNAKE_CMD_CASE_FOLD_EN: fold 'A'..'Z' to lowercase before decode.
module snake_cmd_hub
    import snake_cmd_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tick,
    output logic [2*N_PLAYERS-1:0] dir_o,
    output logic [N_PLAYERS-1:0]   dir_valid_o,
    output logic                   paused_o,
    output logic                   restart_o,
    output logic [N_PLAYERS-1:0]   fifo_full_o,
    output logic [DROP_W-1:0]      drop_cnt_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e                      state_q, state_d;
    logic [N_PLAYERS-1:0][1:0]   dir_q, dir_d;
    logic [N_PLAYERS-1:0]        dir_valid_q, dir_valid_d;
    logic                        restart_q, restart_d;
    logic [DROP_W-1:0]           drop_q, drop_d;

    logic [7:0]                  byte_folded;
    key_t                        key;
    logic                        flush;
    logic                        drop_evt;
    dir_t                        ref_dir;
    logic [N_PLAYERS-1:0]        push, pop;
    logic [N_PLAYERS-1:0][1:0]   fifo_dout, fifo_last;
    logic [N_PLAYERS-1:0][CW-1:0] fifo_count;
    logic [N_PLAYERS-1:0]        fifo_full, fifo_empty;

    // Optional uppercase folding ahead of the key decoder.
    always_comb begin
        byte_folded = rx_data;
`ifdef SNAKE_CMD_CASE_FOLD_EN
        if (rx_data >= 8'h41 && rx_data <= 8'h5A) begin
            byte_folded = rx_data | 8'h20;
        end
`endif
    end

    assign key = decode_key(byte_folded);

    // FSM next state plus turn filter, push/pop/drop and output strobes.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        dir_valid_d = '0;
        restart_d   = 1'b0;
        drop_d      = drop_q;
        flush       = 1'b0;
        drop_evt    = 1'b0;
        ref_dir     = DIR_RIGHT;
        push        = '0;
        pop         = '0;
        if (rx_valid && key.is_restart) begin
            // Restart wins over a coinciding tick.
            restart_d = 1'b1;
            flush     = 1'b1;
            state_d   = ST_RUN;
            dir_d     = '0;
            drop_d    = '0;
        end else begin
            if (rx_valid && key.is_pause) begin
                state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            end
            if (state_q == ST_RUN) begin
                for (int p = 0; p < N_PLAYERS; p++) begin
                    if (tick && !fifo_empty[p]) begin
                        pop[p]         = 1'b1;
                        dir_d[p]       = fifo_dout[p];
                        dir_valid_d[p] = 1'b1;
                    end
                    // Players beyond N_PLAYERS never match here, so their keys vanish.
                    if (rx_valid && key.is_dir && key.player == 2'(p)) begin
                        ref_dir = fifo_empty[p] ? dir_q[p] : fifo_last[p];
                        if (key.dir != ref_dir && key.dir != opposite(ref_dir)) begin
                            if (fifo_count[p] < CW'(FIFO_DEPTH) || pop[p]) begin
                                push[p] = 1'b1;
                            end else begin
                                drop_evt = 1'b1;
                            end
                        end
                    end
                end
            end
            if (drop_evt && drop_q != {DROP_W{1'b1}}) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            dir_q       <= '0;
            dir_valid_q <= '0;
            restart_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            restart_q   <= restart_d;
            drop_q      <= drop_d;
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_fifo
        snake_cmd_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   (key.dir),
            .dout_o  (fifo_dout[g]),
            .last_o  (fifo_last[g]),
            .count_o (fifo_count[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

    assign dir_o       = dir_q;
    assign dir_valid_o = dir_valid_q;
    assign paused_o    = (state_q == ST_PAUSED);
    assign restart_o   = restart_q;
    assign fifo_full_o = fifo_full;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_snake_cmd_hub.sv
// Scoreboard bench for snake_cmd_hub (2 players, depth 4, 8-bit drop counter).
module tb_snake_cmd_hub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tick = 1'b0;
    logic [3:0] dir_o;
    logic [1:0] dir_valid_o;
    logic       paused_o;
    logic       restart_o;
    logic [1:0] fifo_full_o;
    logic [7:0] drop_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Expected output event: {dir_valid, dir, restart}
    typedef struct packed {
        logic [1:0] vld;
        logic [3:0] dir;
        logic       restart;
    } evt_t;
    evt_t exp_q[$];

    snake_cmd_hub #(
        .N_PLAYERS  (2),
        .FIFO_DEPTH (4),
        .DROP_W     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tick        (tick),
        .dir_o       (dir_o),
        .dir_valid_o (dir_valid_o),
        .paused_o    (paused_o),
        .restart_o   (restart_o),
        .fifo_full_o (fifo_full_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic t);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        tick     = t;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
        idle(1);
    endtask

    task automatic do_tick();
        drive(1'b0, 8'h00, 1'b1);
        idle(1);
    endtask

    task automatic expect_evt(input logic [1:0] vld, input logic [3:0] dir, input logic rs);
        evt_t e;
        e.vld = vld;
        e.dir = dir;
        e.restart = rs;
        exp_q.push_back(e);
    endtask

    // Monitor: every output pulse must match the next expected event.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            if (dir_valid_o != 2'b00 || restart_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, dir_valid_o, restart_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event", {25'd0, dir_valid_o, dir_o, restart_o}, {25'd0, e});
                end
            end
        end
    end

    initial begin
        // Reset
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        check("rst_dir", {28'd0, dir_o}, 32'd0);
        check("rst_paused", {31'd0, paused_o}, 32'd0);
        check("rst_restart", {31'd0, restart_o}, 32'd0);
        check("rst_valid", {30'd0, dir_valid_o}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt_o}, 32'd0);
        check("rst_full", {30'd0, fifo_full_o}, 32'd0);

        // 1: 'w' then tick -> P0 UP
        send("w");
        expect_evt(2'b01, 4'b0001, 1'b0);
        do_tick();
        check("t1_dir", {28'd0, dir_o}, 32'h1);

        // 2: P1 at RIGHT, 'j'(LEFT) and 'l'(RIGHT) both rejected
        send("j");
        send("l");
        check("t2_drop", {24'd0, drop_cnt_o}, 32'd0);
        check("t2_full", {30'd0, fifo_full_o}, 32'd0);
        do_tick();
        check("t2_dir", {28'd0, dir_o}, 32'h1);

        // 3: restart to RIGHT, then overfill P0
        expect_evt(2'b00, 4'b0000, 1'b1);
        send("r");
        send("w"); send("a"); send("s"); send("d"); send("w"); send("w");
        check("t3_full", {30'd0, fifo_full_o}, 32'b01);
        check("t3_drop", {24'd0, drop_cnt_o}, 32'd2);
        expect_evt(2'b01, 4'h1, 1'b0); do_tick();
        expect_evt(2'b01, 4'h2, 1'b0); do_tick();
        expect_evt(2'b01, 4'h3, 1'b0); do_tick();
        expect_evt(2'b01, 4'h0, 1'b0); do_tick();
        check("t3_empty", {30'd0, fifo_full_o}, 32'd0);
        // Push into a full FIFO while it pops in the same cycle
        send("w"); send("a"); send("s"); send("d");
        expect_evt(2'b01, 4'h1, 1'b0);
        drive(1'b1, "w", 1'b1);
        idle(1);
        check("t3_pushpop_full", {30'd0, fifo_full_o}, 32'b01);
        check("t3_pushpop_drop", {24'd0, drop_cnt_o}, 32'd2);
        expect_evt(2'b01, 4'h2, 1'b0); do_tick();
        expect_evt(2'b01, 4'h3, 1'b0); do_tick();
        expect_evt(2'b01, 4'h0, 1'b0); do_tick();
        expect_evt(2'b01, 4'h1, 1'b0); do_tick();
        check("t3_drained", {30'd0, fifo_full_o}, 32'd0);

        // 4: pause discards keys and ignores tick
        send("p");
        check("t4_paused", {31'd0, paused_o}, 32'd1);
        send("i");
        do_tick();
        check("t4_dir_hold", {28'd0, dir_o}, 32'h1);
        check("t4_drop", {24'd0, drop_cnt_o}, 32'd2);
        send("p");
        check("t4_resumed", {31'd0, paused_o}, 32'd0);
        do_tick();
        send("i");
        expect_evt(2'b10, 4'b0101, 1'b0);
        do_tick();
        // Key for player 2 is ignored with two players
        send("8");
        do_tick();
        check("t4_p2_ignored", {28'd0, dir_o}, 32'b0101);

        // 5: three P0 entries queued, drop count 5, then restart with tick
        send("a"); send("s"); send("d"); send("w");
        send("a"); send("a"); send("a");
        check("t5_drop5", {24'd0, drop_cnt_o}, 32'd5);
        expect_evt(2'b01, 4'b0110, 1'b0);
        do_tick();
        check("t5_not_full", {30'd0, fifo_full_o}, 32'd0);
        expect_evt(2'b00, 4'h0, 1'b1);
        drive(1'b1, "r", 1'b1);
        idle(1);
        check("t5_dir", {28'd0, dir_o}, 32'd0);
        check("t5_drop", {24'd0, drop_cnt_o}, 32'd0);
        check("t5_full", {30'd0, fifo_full_o}, 32'd0);
        do_tick();
        send("w");
        expect_evt(2'b01, 4'h1, 1'b0);
        do_tick();

        // Restart while paused returns to RUN
        send("p");
        check("t5_paused", {31'd0, paused_o}, 32'd1);
        expect_evt(2'b00, 4'h0, 1'b1);
        send("r");
        check("t5_restart_unpause", {31'd0, paused_o}, 32'd0);
        check("t5_restart_dir", {28'd0, dir_o}, 32'd0);

        // Drop counter saturation
        send("w"); send("a"); send("s"); send("d");
        repeat (260) drive(1'b1, "w", 1'b0);
        idle(1);
        check("sat_drop", {24'd0, drop_cnt_o}, 32'hFF);
        check("sat_full", {30'd0, fifo_full_o}, 32'b01);

        // Mid-operation reset
        send("p");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_dir", {28'd0, dir_o}, 32'd0);
        check("rst2_paused", {31'd0, paused_o}, 32'd0);
        check("rst2_drop", {24'd0, drop_cnt_o}, 32'd0);
        check("rst2_full", {30'd0, fifo_full_o}, 32'd0);
        do_tick();

        // 6: uppercase 'S'
        send(8'h53);
`ifdef SNAKE_CMD_CASE_FOLD_EN
        expect_evt(2'b01, 4'h3, 1'b0);
        do_tick();
        check("t6_dir", {28'd0, dir_o}, 32'h3);
`else
        do_tick();
        check("t6_dir", {28'd0, dir_o}, 32'h0);
`endif

        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
